// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register file and its scoreboard.
package regfile_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREAD = 2;
  localparam int DEF_NREG  = 32;
  localparam int AW        = $clog2(DEF_NREG);

  typedef logic [AW-1:0]       reg_ad_t;
  typedef logic [DEF_XLEN-1:0] xword_t;

endpackage

// File: rtl/regfile_if.sv
// Issue/writeback/read bus of the register file.
// master: pipeline side driving requests; slave: the register file.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREAD = DEF_NREAD,
  parameter int NREG  = DEF_NREG,
  localparam int RAW  = $clog2(NREG)
);

  logic                           w_valid;
  logic [RAW-1:0]                 w_ad;
  logic [XLEN-1:0]                w_data;
  logic                           rsv_valid;
  logic [RAW-1:0]                 rsv_ad;
  logic                           rsv_ready;
  logic                           flush;
  logic [NREAD-1:0]               r_valid;
  logic [NREAD-1:0][RAW-1:0]      r_ad;
  logic [NREAD-1:0][XLEN-1:0]     r_data;
  logic [NREAD-1:0]               r_busy;

  modport master (
    output w_valid, w_ad, w_data, rsv_valid, rsv_ad, flush, r_valid, r_ad,
    input  rsv_ready, r_data, r_busy
  );

  modport slave (
    input  w_valid, w_ad, w_data, rsv_valid, rsv_ad, flush, r_valid, r_ad,
    output rsv_ready, r_data, r_busy
  );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy scoreboard: reservation handshake, writeback release,
// flush. Priority per register: flush > accepted reservation > writeback.
// Register 0 never becomes busy.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  localparam int RAW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            w_valid,
  input  logic [RAW-1:0]  w_ad,
  input  logic            rsv_valid,
  input  logic [RAW-1:0]  rsv_ad,
  input  logic            flush,
  output logic            rsv_ready,
  output logic            rsv_acc,
  output logic [NREG-1:0] busy
);

  // A reservation may proceed if the target is free, is being released by a
  // writeback this very cycle, or is x0 (accepted and dropped).
  always_comb begin
    rsv_ready = !busy[rsv_ad] || (w_valid && (w_ad == rsv_ad)) || (rsv_ad == '0);
    rsv_acc   = rsv_valid && rsv_ready;
  end

  // Busy vector update with flush/set/clear priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every bit is
      // computed from the pre-edge values regardless of statement order.
      busy[0] <= 1'b0;
      for (int i = 1; i < NREG; i++) begin
        if (flush)
          busy[i] <= 1'b0;
        else if (rsv_acc && (rsv_ad == RAW'(i)))
          busy[i] <= 1'b1;
        else if (w_valid && (w_ad == RAW'(i)))
          busy[i] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port integer register file with busy scoreboard; x0 reads zero.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREAD = DEF_NREAD,
  parameter int NREG  = DEF_NREG,
  localparam int RAW  = $clog2(NREG)
) (
  input  logic     clk,
  input  logic     rst_n,
  regfile_if.slave bus
);

  logic [XLEN-1:0]            mem [1:NREG-1];
  logic [NREG-1:0]            busy;
  logic                       rsv_acc;
  logic [NREAD-1:0][XLEN-1:0] rd_word;
  logic [NREAD-1:0]           rd_busy;

  rf_scoreboard #(.NREG(NREG)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .w_valid   (bus.w_valid),
    .w_ad      (bus.w_ad),
    .rsv_valid (bus.rsv_valid),
    .rsv_ad    (bus.rsv_ad),
    .flush     (bus.flush),
    .rsv_ready (bus.rsv_ready),
    .rsv_acc   (rsv_acc),
    .busy      (busy)
  );

  // Writeback into the data array; x0 has no storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the array is flop-based and must clear on reset, so it is reset
      // explicitly here rather than left to a RAM macro's undefined contents.
      for (int i = 1; i < NREG; i++) mem[i] <= '0;
    end else if (bus.w_valid && (bus.w_ad != '0)) begin
      mem[bus.w_ad] <= bus.w_data;
    end
  end

  // Per-port read value and busy flag as seen at this edge.
  always_comb begin
    for (int p = 0; p < NREAD; p++) begin
      rd_word[p] = '0;
      rd_busy[p] = 1'b0;
      if (bus.r_ad[p] != '0) begin
        rd_word[p] = mem[bus.r_ad[p]];
        rd_busy[p] = busy[bus.r_ad[p]];
`ifdef REGFILE_BYPASS_EN
        if (bus.w_valid && (bus.w_ad == bus.r_ad[p])) begin
          rd_word[p] = bus.w_data;
          rd_busy[p] = rsv_acc && !bus.flush && (bus.rsv_ad == bus.r_ad[p]);
        end
`endif
      end
    end
  end

`ifndef REGFILE_BYPASS_EN
  // Acceptance is only needed by the bypass path.
  logic unused_rsv_acc;
  assign unused_rsv_acc = rsv_acc;
`endif

  // Registered read ports; an idle port holds its last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.r_data <= '0;
      bus.r_busy <= '0;
    end else begin
      for (int p = 0; p < NREAD; p++) begin
        if (bus.r_valid[p]) begin
          bus.r_data[p] <= rd_word[p];
          bus.r_busy[p] <= rd_busy[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb (XLEN=32, NREAD=2, NREG=32).
module tb_regfile_sb;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  regfile_if #(.XLEN(32), .NREAD(2), .NREG(32)) bus ();

  regfile_sb #(.XLEN(32), .NREAD(2), .NREG(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input xword_t obs, input xword_t exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.w_valid   = 1'b0;
    bus.rsv_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.r_valid   = '0;
  endtask

  initial begin
    idle();
    bus.w_ad   = '0;
    bus.w_data = '0;
    bus.rsv_ad = '0;
    bus.r_ad   = '0;
    #12;
    check("rst_rdata0", bus.r_data[0], 32'h0);
    check("rst_rdata1", bus.r_data[1], 32'h0);
    check("rst_rbusy", {30'b0, bus.r_busy}, 32'h0);
    check("rst_ready", {31'b0, bus.rsv_ready}, 32'h1);
    rst_n = 1'b1;
    step();

    // Read x5 on port 0, x0 on port 1.
    bus.r_valid = 2'b11; bus.r_ad[0] = 5'd5; bus.r_ad[1] = 5'd0;
    step();
    check("rd_x5_p0", bus.r_data[0], 32'h0);
    check("rd_x0_p1", bus.r_data[1], 32'h0);
    check("rd_busy_init", {30'b0, bus.r_busy}, 32'h0);
    idle();

    // Write x3 then read it on both ports.
    bus.w_valid = 1'b1; bus.w_ad = 5'd3; bus.w_data = 32'hDEADBEEF;
    step();
    idle();
    bus.r_valid = 2'b11; bus.r_ad[0] = 5'd3; bus.r_ad[1] = 5'd3;
    step();
    check("rd_x3_p0", bus.r_data[0], 32'hDEADBEEF);
    check("rd_x3_p1", bus.r_data[1], 32'hDEADBEEF);
    idle();

    // Writes to x0 are ignored.
    bus.w_valid = 1'b1; bus.w_ad = 5'd0; bus.w_data = 32'h1234;
    step();
    idle();
    bus.r_valid = 2'b01; bus.r_ad[0] = 5'd0;
    step();
    check("rd_x0_after_wr", bus.r_data[0], 32'h0);
    idle();

    // Reserve x7; a second reservation must be refused.
    bus.rsv_valid = 1'b1; bus.rsv_ad = 5'd7;
    #1 check("rsv7_ready_first", {31'b0, bus.rsv_ready}, 32'h1);
    step();
    check("rsv7_ready_again", {31'b0, bus.rsv_ready}, 32'h0);
    idle();
    bus.r_valid = 2'b10; bus.r_ad[1] = 5'd7;
    step();
    check("rd_x7_busy", {31'b0, bus.r_busy[1]}, 32'h1);
    idle();
    // Writeback releases x7 (port 1 idle, holds busy=1).
    bus.w_valid = 1'b1; bus.w_ad = 5'd7; bus.w_data = 32'h55;
    #1 check("ready_during_wb", {31'b0, bus.rsv_ready}, 32'h1);
    step();
    idle();
    check("p1_holds_busy", {31'b0, bus.r_busy[1]}, 32'h1);
    bus.r_valid = 2'b10; bus.r_ad[1] = 5'd7;
    step();
    check("rd_x7_data", bus.r_data[1], 32'h55);
    check("rd_x7_free", {31'b0, bus.r_busy[1]}, 32'h0);
    check("rsv7_ready_after", {31'b0, bus.rsv_ready}, 32'h1);
    idle();

    // Same-cycle write and read of x9.
    bus.w_valid = 1'b1; bus.w_ad = 5'd9; bus.w_data = 32'hA5A5A5A5;
    bus.r_valid = 2'b01; bus.r_ad[0] = 5'd9;
    step();
`ifdef REGFILE_BYPASS_EN
    check("same_cyc_x9", bus.r_data[0], 32'hA5A5A5A5);
`else
    check("same_cyc_x9", bus.r_data[0], 32'h0);
`endif
    check("same_cyc_x9_busy", {31'b0, bus.r_busy[0]}, 32'h0);
    idle();
    bus.r_valid = 2'b01; bus.r_ad[0] = 5'd9;
    step();
    check("rd_x9_next", bus.r_data[0], 32'hA5A5A5A5);
    idle();

    // Same-cycle write, reservation and read of x10: new producer wins.
    bus.w_valid = 1'b1; bus.w_ad = 5'd10; bus.w_data = 32'h11;
    bus.rsv_valid = 1'b1; bus.rsv_ad = 5'd10;
    bus.r_valid = 2'b01; bus.r_ad[0] = 5'd10;
    step();
`ifdef REGFILE_BYPASS_EN
    check("wr_rsv_x10_data", bus.r_data[0], 32'h11);
    check("wr_rsv_x10_busy", {31'b0, bus.r_busy[0]}, 32'h1);
`else
    check("wr_rsv_x10_data", bus.r_data[0], 32'h0);
    check("wr_rsv_x10_busy", {31'b0, bus.r_busy[0]}, 32'h0);
`endif
    idle();
    bus.r_valid = 2'b01; bus.r_ad[0] = 5'd10;
    step();
    check("x10_after_data", bus.r_data[0], 32'h11);
    check("x10_after_busy", {31'b0, bus.r_busy[0]}, 32'h1);
    idle();

    // Reserve x4 and x6, then flush alongside a reservation of x8.
    bus.rsv_valid = 1'b1; bus.rsv_ad = 5'd4;
    step();
    bus.rsv_ad = 5'd6;
    step();
    bus.rsv_ad = 5'd8; bus.flush = 1'b1;
    #1 check("ready_x8_flush", {31'b0, bus.rsv_ready}, 32'h1);
    step();
    idle();
    bus.r_valid = 2'b11; bus.r_ad[0] = 5'd4; bus.r_ad[1] = 5'd6;
    step();
    check("flush_x4_x6", {30'b0, bus.r_busy}, 32'h0);
    bus.r_ad[0] = 5'd8; bus.r_ad[1] = 5'd10;
    step();
    check("flush_x8_x10", {30'b0, bus.r_busy}, 32'h0);
    idle();

    // Write x2, reserve it, read it, then reset mid-cycle.
    bus.w_valid = 1'b1; bus.w_ad = 5'd2; bus.w_data = 32'hFF;
    step();
    idle();
    bus.rsv_valid = 1'b1; bus.rsv_ad = 5'd2;
    step();
    idle();
    bus.r_valid = 2'b01; bus.r_ad[0] = 5'd2; bus.rsv_ad = 5'd2;
    step();
    check("pre_rst_x2_data", bus.r_data[0], 32'hFF);
    check("pre_rst_x2_busy", {31'b0, bus.r_busy[0]}, 32'h1);
    idle();
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_rdata", bus.r_data[0], 32'h0);
    check("mid_rst_rbusy", {30'b0, bus.r_busy}, 32'h0);
    check("mid_rst_ready", {31'b0, bus.rsv_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.r_valid = 2'b11; bus.r_ad[0] = 5'd2; bus.r_ad[1] = 5'd3;
    step();
    check("post_rst_x2_data", bus.r_data[0], 32'h0);
    check("post_rst_x2_busy", {31'b0, bus.r_busy[0]}, 32'h0);
    check("post_rst_x3_data", bus.r_data[1], 32'h0);
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port integer register file with a per-register busy scoreboard, placed between decode/issue and writeback in the CPU pipeline. Issue reserves a destination register, writeback stores the result and releases the reservation, and operand reads return data plus a busy flag so the issue stage can stall or forward. Register x0 is hardwired to zero.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREAD, 2, number of read ports (1..4)
- NREG, 32, number of architectural registers (power of two); AW = $clog2(NREG)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- w_valid  in  1  writeback strobe
- w_ad  in  AW  writeback register address
- w_data  in  XLEN  writeback data
- rsv_valid  in  1  issue requests reservation of rsv_ad
- rsv_ad  in  AW  destination register to reserve
- rsv_ready  out  1  reservation can be accepted this cycle (combinational)
- flush  in  1  pipeline flush; clears all busy bits
- r_valid  in  NREAD  per-port read request
- r_ad  in  NREAD x AW  per-port read address
- r_data  out  NREAD x XLEN  per-port read data, registered
- r_busy  out  NREAD  per-port busy flag for the read register, registered

## Operation
- Storage: NREG x XLEN array plus NREG-bit busy vector; entry 0 has no storage and no busy bit.
- Write: on w_valid with w_ad != 0, register[w_ad] <= w_data and busy[w_ad] <= 0. w_ad == 0 is ignored.
- Reservation handshake: accepted when rsv_valid && rsv_ready; sets busy[rsv_ad]. rsv_ready = !busy[rsv_ad] || (w_valid && w_ad == rsv_ad) || rsv_ad == 0. Reserving x0 is accepted and has no effect. Only one outstanding write per register.
- Same-cycle reservation and write to same address: write data stored, busy ends set (new producer wins).
- flush: all busy bits cleared next edge; overrides a same-cycle reservation (rsv_ready is still driven, the accepted reservation is discarded). A same-cycle write still stores data.
- Read: when r_valid[i], r_data[i] <= value of register[r_ad[i]] and r_busy[i] <= busy[r_ad[i]]; r_ad[i] == 0 yields 0 / not busy. When r_valid[i] low, r_data[i] and r_busy[i] hold.
- Multiple ports reading the same address return identical results.

## Timing
- Reset (async assert, sync-to-clk deassert by upstream): all registers 0, all busy 0, r_data 0, r_busy 0; rsv_ready therefore 1.
- Read latency: 1 cycle (request at edge N, data valid after edge N).
- Write visible to reads requested in the following cycle; same-cycle behaviour set by Configuration.
- Busy set by reservation at edge N is seen by reads requested from cycle N+1.
- Reset mid-operation: all state and outputs return to reset values immediately; pending reservations lost.

## Configuration
- REGFILE_BYPASS_EN defined: a read requested in the same cycle as a write to the same nonzero address returns w_data with r_busy 0 (unless a same-cycle accepted reservation of that address without flush, then busy 1).
- Not defined: that read returns the pre-write value and pre-write busy state; no bypass mux is built.

## Structure
- Package regfile_pkg: XLEN default, NREG default, AW localparam, typedef reg_ad_t (logic [AW-1:0]), typedef xword_t (logic [XLEN-1:0]).
- Sub-module rf_scoreboard: busy vector, rsv_ready, flush and set/clear priority; top holds data array and read ports.

## Test plan
- Reset then read x5 and x0 on both ports -> r_data 0, r_busy 0, rsv_ready 1.
- Write x3 = 0xDEADBEEF, next cycle read x3 on port 0 and port 1 -> both 0xDEADBEEF; write x0 = 0x1234 then read x0 -> 0.
- Reserve x7, next cycle rsv_valid x7 -> rsv_ready 0; read x7 -> r_busy 1; write x7 = 0x55 -> next read 0x55, r_busy 0, rsv_ready 1.
- Same-cycle write x9 = 0xA5A5A5A5 and read x9 -> 0xA5A5A5A5 with REGFILE_BYPASS_EN, old value (0) without.
- Reserve x4 and x6, then flush concurrent with rsv_valid x8 -> x4, x6, x8 all not busy afterwards.
- Write x2 = 0xFF, reserve x2, assert rst_n low mid-cycle -> r_data 0, x2 reads 0 not busy after reset.
